// File: rtl/add8_seq_ctrl_pkg.sv
// Shared types and sizing constants for the byte-serial add/subtract sequencer.
package add_seq_pkg;

  localparam int BYTE_W     = 8;
  localparam int NBYTES_MAX = 16;
  localparam int IDX_W      = $clog2(NBYTES_MAX);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/add8_seq_ctrl_if.sv
// Operand/result handshake bundle between a requester (master) and the sequencer (slave).
interface add8_seq_ctrl_if #(
  parameter int NBYTES = 4
);

  logic                  in_valid;
  logic                  in_ready;
  logic                  op_sub;
  logic [8*NBYTES-1:0]   a;
  logic [8*NBYTES-1:0]   b;
  logic                  out_valid;
  logic                  out_ready;
  logic [8*NBYTES-1:0]   sum;
  logic                  carry;
  logic                  overflow;

  modport master (
    output in_valid, op_sub, a, b, out_ready,
    input  in_ready, out_valid, sum, carry, overflow
  );

  modport slave (
    input  in_valid, op_sub, a, b, out_ready,
    output in_ready, out_valid, sum, carry, overflow
  );

endinterface

// File: rtl/add8_seq_ctrl_add8.sv
// Shared 8-bit ripple-carry byte adder used once per RUN cycle by the sequencer.
module Add8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       ci_i,
  output logic [7:0] s_o,
  output logic       co_o
);

  logic rippleC;

  always_comb begin
    s_o     = '0;
    rippleC = ci_i;
    for (int i = 0; i < 8; i++) begin
      s_o[i]  = a_i[i] ^ b_i[i] ^ rippleC;
      rippleC = (a_i[i] & b_i[i]) | (rippleC & (a_i[i] ^ b_i[i]));
    end
    co_o = rippleC;
  end

endmodule

// File: rtl/add8_seq_ctrl.sv
// Multi-byte add/subtract sequencer: one byte per clock, LSB first, carry chained in a register.
// Define ADDSEQ_SUB_EN to enable subtraction (op_sub inverts b and injects carry-in of 1).
module add8_seq_ctrl
  import add_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  add8_seq_ctrl_if.slave  bus
);

  localparam int                W        = BYTE_W * NBYTES;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NBYTES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             cin_q, cin_d;
  logic [W-1:0]     aOp_q, aOp_d;
  logic [W-1:0]     bEff_q, bEff_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic [BYTE_W-1:0] aByte, bByte, addS;
  logic              addCo;

  assign aByte = aOp_q[idx_q*BYTE_W +: BYTE_W];
  assign bByte = bEff_q[idx_q*BYTE_W +: BYTE_W];

  Add8 u_add8 (
    .a_i  (aByte),
    .b_i  (bByte),
    .ci_i (cin_q),
    .s_o  (addS),
    .co_o (addCo)
  );

`ifndef ADDSEQ_SUB_EN
  logic unusedOpSub;
  assign unusedOpSub = bus.op_sub;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cin_d   = cin_q;
    aOp_d   = aOp_q;
    bEff_d  = bEff_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          aOp_d   = bus.a;
          idx_d   = '0;
`ifdef ADDSEQ_SUB_EN
          bEff_d  = bus.op_sub ? ~bus.b : bus.b;
          cin_d   = bus.op_sub;
`else
          bEff_d  = bus.b;
          cin_d   = 1'b0;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*BYTE_W +: BYTE_W] = addS;
        cin_d = addCo;
        idx_d = idx_q + 1'b1;
        // Last byte: latch the final flags; overflow uses the full-width operand sign bits.
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          carry_d = addCo;
          ovf_d   = (aOp_q[W-1] == bEff_q[W-1]) && (addS[BYTE_W-1] != aOp_q[W-1]);
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cin_q   <= 1'b0;
      aOp_q   <= '0;
      bEff_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cin_q   <= cin_d;
      aOp_q   <= aOp_d;
      bEff_q  <= bEff_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = ovf_q;

endmodule
